// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode pipeline types: the queued (PC, instruction) pair and default sizing.
package fetch_queue_pkg;

    localparam int N_DEF     = 64;
    localparam int W_DEF     = 32;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [N_DEF-1:0] pc;
        logic [W_DEF-1:0] instr;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: un-reset register array with one write port and a combinational read port.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = N_DEF + W_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode; a taken branch (flush_Q) empties it at the next edge.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_F,
    input  logic [N-1:0]  pc_F,
    input  logic [W-1:0]  instr_F,
    output logic          ready_F,
    output logic          valid_D,
    output logic [N-1:0]  pc_D,
    output logic [W-1:0]  instr_D,
    input  logic          ready_D,
    input  logic          flush_Q,
    output logic [CW-1:0] count_Q
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic [N+W-1:0] head;

    // Handshake readiness depends only on registered count, never on ready_D.
    assign ready_F = (count != FULL);
    assign valid_D = (count != '0);
    assign push    = valid_F & ready_F & ~flush_Q;
    assign pop     = valid_D & ready_D & ~flush_Q;
    assign count_Q = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_Q) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (N + W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({pc_F, instr_F}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Empty queue drives zeros so stale storage never leaks to decode.
    assign pc_D    = valid_D ? head[N+W-1:W] : '0;
    assign instr_D = valid_D ? head[W-1:0]   : '0;

endmodule
